// File: rtl/dmem_pkg.sv
// Shared constants for the dmem responder: MMIO offsets, TXSTAT bit layout and field widths.
package dmem_pkg;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [1:0] OFF_CYCLE  = 2'd0;
  localparam logic [1:0] OFF_LED    = 2'd1;
  localparam logic [1:0] OFF_TXDATA = 2'd2;
  localparam logic [1:0] OFF_TXSTAT = 2'd3;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_CNT_LSB   = 2;
  localparam int STAT_CNT_MSB   = 4;
  localparam int STAT_OVF_BIT   = 5;

  localparam int LED_W = 16;
  localparam int TXB_W = 8;

  function automatic logic [31:0] txstat_pack(input logic full, input logic empty,
                                              input logic [2:0] cnt, input logic ovf);
    logic [31:0] s;
    s = '0;
    s[STAT_FULL_BIT]                = full;
    s[STAT_EMPTY_BIT]               = empty;
    s[STAT_CNT_MSB:STAT_CNT_LSB]    = cnt;
    s[STAT_OVF_BIT]                 = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with combinational head output (zero when empty) and an occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO may still accept a push when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_dout    = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: read-first RAM in the low half, CYCLE/LED/TX-FIFO MMIO in the high half.
// The TX FIFO with TXDATA/TXSTAT is built only when DMEM_TXFIFO_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int RAM_ADDR_W = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      address_dmem,
  input  logic [31:0]      data,
  input  logic             wren,
  output logic [31:0]      q_dmem,
  output logic [LED_W-1:0] led,
  output logic [TXB_W-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_W;

  logic [31:0]           r_ram [RAM_WORDS];
  logic [31:0]           r_ram_q;
  logic                  r_sel_ram;
  logic [31:0]           r_mmio_q;
  logic [31:0]           r_cycle;
  logic [LED_W-1:0]      r_led;

  logic                  w_is_ram;
  logic                  w_mmio_hit;
  logic [1:0]            w_off;
  logic [RAM_ADDR_W-1:0] w_ram_idx;
  logic [31:0]           w_mmio_rd;
  logic [31:0]           w_txstat;

  assign w_is_ram   = ~address_dmem[31];
  assign w_mmio_hit = (address_dmem[31:2] == MMIO_BASE[31:2]);
  assign w_off      = address_dmem[1:0];
  assign w_ram_idx  = address_dmem[RAM_ADDR_W-1:0];

  // Read-first single-port RAM; no reset so it maps onto block memory.
  always_ff @(posedge clock) begin
    if (wren && w_is_ram) r_ram[w_ram_idx] <= data;
    r_ram_q <= r_ram[w_ram_idx];
  end

`ifdef DMEM_TXFIFO_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_clr_ovf;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [TXB_W-1:0] w_head;
  logic             r_ovf;

  function automatic logic [2:0] cnt_sat(input logic [CNT_W-1:0] c);
    logic [31:0] cv;
    cv = 32'(c);
    return (cv > 32'd7) ? 3'd7 : cv[2:0];
  endfunction

  assign w_push_req = wren && w_mmio_hit && (w_off == OFF_TXDATA);
  assign w_clr_ovf  = wren && w_mmio_hit && (w_off == OFF_TXSTAT);
  assign w_pop      = ~w_empty && tx_ready;
  assign w_push     = w_push_req && (~w_full || w_pop);

  sync_fifo #(
    .WIDTH (TXB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_txfifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (data[TXB_W-1:0]),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_push_req && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_txstat = txstat_pack(w_full, w_empty, cnt_sat(w_count), r_ovf);
  assign tx_valid = ~w_empty;
  assign tx_data  = w_head;
`else
  logic w_unused_tx;

  assign w_unused_tx = tx_ready;
  assign w_txstat    = '0;
  assign tx_valid    = 1'b0;
  assign tx_data     = '0;
`endif

  always_comb begin
    w_mmio_rd = '0;
    if (w_mmio_hit) begin
      case (w_off)
        OFF_CYCLE:  w_mmio_rd = r_cycle;
        OFF_LED:    w_mmio_rd = 32'(r_led);
        OFF_TXSTAT: w_mmio_rd = w_txstat;
        default:    w_mmio_rd = '0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle   <= '0;
      r_led     <= '0;
      r_sel_ram <= 1'b0;
      r_mmio_q  <= '0;
    end else begin
      r_cycle   <= r_cycle + 32'd1;
      if (wren && w_mmio_hit && (w_off == OFF_LED)) r_led <= data[LED_W-1:0];
      r_sel_ram <= w_is_ram;
      r_mmio_q  <= w_mmio_rd;
    end
  end

  // Both read paths are registered; only the final select is combinational.
  assign q_dmem = r_sel_ram ? r_ram_q : r_mmio_q;
  assign led    = r_led;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a queue-based reference model.
module tb_dmem_responder;

  localparam int DEPTH = 4;
`ifdef DMEM_TXFIFO_EN
  localparam bit FIFO_EN = 1'b1;
`else
  localparam bit FIFO_EN = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  dmem_responder #(
    .RAM_ADDR_W (12),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .led          (led),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_ram   [4096];
  bit          m_known [4096];
  logic [7:0]  m_fifo  [$];
  logic        m_ovf;
  logic [15:0] m_led;
  logic [31:0] m_cycle;
  logic [31:0] last_q;

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_LED    = 32'h8000_0001;
  localparam logic [31:0] A_TXDATA = 32'h8000_0002;
  localparam logic [31:0] A_TXSTAT = 32'h8000_0003;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_txstat();
    int n;
    logic [2:0] c;
    n = m_fifo.size();
    c = (n > 7) ? 3'd7 : 3'(n);
    if (!FIFO_EN) return 32'h0;
    return {26'b0, m_ovf, c, (n == 0), (n == DEPTH)};
  endfunction

  task automatic m_reset();
    m_fifo.delete();
    m_ovf   = 1'b0;
    m_led   = 16'h0;
    m_cycle = 32'h0;
  endtask

  // One processor access: check outputs, advance model, apply one edge, check the registered read.
  task automatic step(input logic [31:0] addr, input logic [31:0] dat, input logic we, input logic rdy);
    int          n;
    logic [7:0]  head;
    logic [31:0] exp_q;
    bit          chk_q;
    bit          pop;
    bit          push_req;
    int          idx;
    n    = m_fifo.size();
    head = (n > 0) ? m_fifo[0] : 8'h00;
    check_val("tx_valid", 32'(tx_valid), 32'(FIFO_EN && (n > 0)));
    check_val("tx_data", 32'(tx_data), FIFO_EN ? 32'(head) : 32'h0);
    idx   = int'(addr[11:0]);
    chk_q = 1'b1;
    exp_q = 32'h0;
    if (!addr[31]) begin
      chk_q = m_known[idx];
      exp_q = m_ram[idx];
    end else if (addr[30:2] == 29'h0) begin
      case (addr[1:0])
        2'd0:    exp_q = m_cycle;
        2'd1:    exp_q = {16'h0, m_led};
        2'd3:    exp_q = m_txstat();
        default: exp_q = 32'h0;
      endcase
    end
    pop      = FIFO_EN && (n > 0) && rdy;
    push_req = FIFO_EN && we && (addr == A_TXDATA);
    if (pop) void'(m_fifo.pop_front());
    if (push_req) begin
      if ((n < DEPTH) || pop) m_fifo.push_back(dat[7:0]);
      else m_ovf = 1'b1;
    end
    if (FIFO_EN && we && (addr == A_TXSTAT)) m_ovf = 1'b0;
    if (we && (addr == A_LED)) m_led = dat[15:0];
    if (we && !addr[31]) begin
      m_ram[idx]   = dat;
      m_known[idx] = 1'b1;
    end
    m_cycle = m_cycle + 32'd1;
    address_dmem = addr;
    data         = dat;
    wren         = we;
    tx_ready     = rdy;
    @(posedge clock);
    #1;
    if (chk_q) check_val("q_dmem", q_dmem, exp_q);
    check_val("led", 32'(led), 32'(m_led));
    last_q = q_dmem;
  endtask

  logic [31:0] c0;
  logic [31:0] raddr;

  initial begin
    for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
    reset = 1'b1; address_dmem = '0; data = '0; wren = 1'b0; tx_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clock);
    #1;
    check_val("rst_q", q_dmem, 32'h0);
    check_val("rst_led", 32'(led), 32'h0);
    check_val("rst_txv", 32'(tx_valid), 32'h0);
    check_val("rst_txd", 32'(tx_data), 32'h0);
    reset = 1'b0;

    step(A_TXSTAT, 32'h0, 1'b0, 1'b0);
    check_val("stat_reset", last_q, FIFO_EN ? 32'h02 : 32'h0);

    // RAM write, read, alias, read-first
    step(32'h0000_0005, 32'hDEAD_BEEF, 1'b1, 1'b0);
    step(32'h0000_0005, 32'h0, 1'b0, 1'b0);
    check_val("ram_rd", last_q, 32'hDEAD_BEEF);
    step(32'h0000_1005, 32'h0, 1'b0, 1'b0);
    check_val("ram_alias", last_q, 32'hDEAD_BEEF);
    step(32'h0000_0007, 32'h0000_1111, 1'b1, 1'b0);
    step(32'h0000_0007, 32'h0000_2222, 1'b1, 1'b0);
    check_val("ram_rdfirst", last_q, 32'h0000_1111);
    step(32'h0000_0007, 32'h0, 1'b0, 1'b0);
    check_val("ram_newdata", last_q, 32'h0000_2222);

    // LED and CYCLE
    step(A_LED, 32'hFFFF_ABCD, 1'b1, 1'b0);
    check_val("led_val", 32'(led), 32'h0000_ABCD);
    step(A_LED, 32'h0, 1'b0, 1'b0);
    check_val("led_rd", last_q, 32'h0000_ABCD);
    step(A_CYCLE, 32'h0, 1'b1, 1'b0);
    c0 = last_q;
    repeat (9) step(A_LED, 32'h0, 1'b0, 1'b0);
    step(A_CYCLE, 32'h0, 1'b0, 1'b0);
    check_val("cycle_delta", last_q - c0, 32'd10);

    // Fill past full with the consumer stalled
    for (int b = 8'h41; b <= 8'h45; b++) step(A_TXDATA, 32'(b), 1'b1, 1'b0);
    step(A_TXSTAT, 32'h0, 1'b0, 1'b0);
    check_val("stat_full_ovf", last_q, FIFO_EN ? 32'h31 : 32'h0);
    check_val("head_first", 32'(tx_data), FIFO_EN ? 32'h41 : 32'h0);
    step(A_TXSTAT, 32'h0, 1'b1, 1'b0);
    step(A_TXSTAT, 32'h0, 1'b0, 1'b0);
    check_val("stat_ovf_clr", last_q, FIFO_EN ? 32'h11 : 32'h0);

    // Drain
    repeat (4) step(A_LED, 32'h0, 1'b0, 1'b1);
    step(A_TXSTAT, 32'h0, 1'b0, 1'b1);
    check_val("stat_drained", last_q, FIFO_EN ? 32'h02 : 32'h0);

    // Push and pop together on a full FIFO
    for (int b = 8'h61; b <= 8'h64; b++) step(A_TXDATA, 32'(b), 1'b1, 1'b0);
    step(A_TXDATA, 32'h0000_0055, 1'b1, 1'b1);
    step(A_TXSTAT, 32'h0, 1'b0, 1'b0);
    check_val("stat_pushpop", last_q, FIFO_EN ? 32'h11 : 32'h0);

    // Reset in the middle of a drain
    step(A_LED, 32'h0, 1'b0, 1'b1);
    wren = 1'b0;
    reset = 1'b1;
    #2;
    check_val("mid_rst_txv", 32'(tx_valid), 32'h0);
    check_val("mid_rst_txd", 32'(tx_data), 32'h0);
    check_val("mid_rst_led", 32'(led), 32'h0);
    check_val("mid_rst_q", q_dmem, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tx_ready = 1'b0;
    m_reset();
    step(A_TXSTAT, 32'h0, 1'b0, 1'b0);
    check_val("stat_after_rst", last_q, FIFO_EN ? 32'h02 : 32'h0);
    step(32'h0000_0005, 32'h0, 1'b0, 1'b0);
    check_val("ram_kept", last_q, 32'hDEAD_BEEF);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    raddr = {1'b0, 19'($urandom), 8'h00, 4'($urandom_range(0, 15))};
        2:       raddr = A_CYCLE | 32'($urandom_range(0, 3));
        3:       raddr = A_TXDATA;
        4:       raddr = A_TXSTAT;
        default: raddr = A_CYCLE | (32'($urandom_range(1, 255)) << 2) | 32'($urandom_range(0, 3));
      endcase
      step(raddr, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
